// File: rtl/sequence_generator.sv
// sequence_generator: repeats a latched WIDTH-bit pattern MSB first with optional idle gaps
module sequence_generator #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int GAP = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             data_out,
  output logic             data_valid,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shift_reg, pat_reg;
  logic [BW-1:0] bit_cnt;
  logic [REP_W-1:0] rep_left;
  logic last_bit, gap_last;
  assign last_bit = bit_cnt == '0;
  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gap_cnt;
    // gap counter: loaded on entry to the gap, counts down to its last cycle
    always_ff @(posedge clk)
      gap_cnt <= reset ? '0
               : (state == S_SEND && state_nx == S_GAP) ? GW'(GAP - 1)
               : (state == S_GAP && gap_cnt != '0) ? gap_cnt - 1'b1
               : gap_cnt;
    assign gap_last = gap_cnt == '0;
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_nx;
  // next state; abort beats start and cancels any active phase without a done pulse
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = (start && !abort) ? S_SEND : S_IDLE;
      S_SEND: state_nx = abort ? S_IDLE
                       : !last_bit ? S_SEND
                       : rep_left == '0 ? S_DONE
                       : (GAP > 0) ? S_GAP : S_SEND;
      S_GAP:  state_nx = abort ? S_IDLE : gap_last ? S_SEND : S_GAP;
      default: state_nx = S_IDLE;
    endcase
  end
  // datapath: latch on acceptance, shift per bit, reload the pattern copy between repetitions
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      pat_reg <= '0;
      bit_cnt <= '0;
      rep_left <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      shift_reg <= pattern;
      pat_reg <= pattern;
      rep_left <= reps;
      bit_cnt <= BW'(WIDTH - 1);
    end else if (state == S_SEND && !abort) begin
      if (last_bit && rep_left != '0) begin
        shift_reg <= pat_reg;
        rep_left <= rep_left - 1'b1;
        bit_cnt <= BW'(WIDTH - 1);
      end else begin
        shift_reg <= shift_reg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end
  // outputs decoded from the registered state
  always_comb begin
    ready = state == S_IDLE;
    busy = state != S_IDLE;
    data_valid = state == S_SEND;
    data_out = data_valid ? shift_reg[WIDTH-1] : IDLE_LEVEL;
    done = state == S_DONE;
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: gapped and back-to-back instances checked against a cycle-index model
module tb_sequence_generator;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] pattern = '0, reps = '0;
  logic ready[2], busy[2], data_out[2], data_valid[2], done[2];
  int checks = 0, failures = 0;
  logic active[2];
  logic [3:0] m_pat[2];
  int m_reps[2], m_n[2];

  always #5 clk = ~clk;

  sequence_generator #(.WIDTH(4), .REP_W(4), .GAP(1), .IDLE_LEVEL(1'b0)) u_gap (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps), .abort(abort),
    .ready(ready[0]), .busy(busy[0]), .data_out(data_out[0]), .data_valid(data_valid[0]), .done(done[0]));

  sequence_generator #(.WIDTH(4), .REP_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) u_b2b (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps), .abort(abort),
    .ready(ready[1]), .busy(busy[1]), .data_out(data_out[1]), .data_valid(data_valid[1]), .done(done[1]));

  function automatic int gap_of(input int k);
    return k == 0 ? 1 : 0;
  endfunction

  // expected {ready,busy,valid,data,done} for cycle n of a transfer
  function automatic logic [4:0] expv(input logic [3:0] p, input int rp, input int g, input int n);
    int per, tot, i;
    per = 4 + g;
    tot = (rp + 1) * 4 + rp * g;
    i = n % per;
    if (n == tot) return 5'b01001;
    if (i < 4) return {3'b011, p[3 - i], 1'b0};
    return 5'b01000;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (reset) active[k] = 1'b0;
      else if (active[k]) begin
        if (abort) active[k] = 1'b0;
        else begin
          m_n[k] = m_n[k] + 1;
          if (m_n[k] > (m_reps[k] + 1) * 4 + m_reps[k] * gap_of(k)) active[k] = 1'b0;
        end
      end else if (start && !abort) begin
        active[k] = 1'b1;
        m_pat[k] = pattern;
        m_reps[k] = int'(reps);
        m_n[k] = 0;
      end
    end

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got {rdy,busy,vld,dat,done}=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic r, input logic [3:0] p,
                      input logic [3:0] rp, input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      start = s;
      abort = a;
      reset = r;
      pattern = p;
      reps = rp;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        check($sformatf("%s[%0d]", tag, k),
              {ready[k], busy[k], data_valid[k], data_out[k], done[k]},
              active[k] ? expv(m_pat[k], m_reps[k], gap_of(k), m_n[k]) : 5'b10000);
    end
  endtask

  initial begin
    step(0, 0, 1, 4'h0, 4'h0, 2, "reset");
    step(0, 0, 0, 4'h0, 4'h0, 4, "idle");
    step(1, 0, 0, 4'b1011, 4'd0, 1, "single");
    step(0, 0, 0, 4'b0110, 4'd3, 8, "single");
    step(1, 0, 0, 4'b1011, 4'd2, 1, "repgap");
    step(0, 0, 0, 4'b1011, 4'd2, 18, "repgap");
    step(1, 0, 0, 4'b1100, 4'd1, 1, "b2b");
    step(0, 0, 0, 4'b1100, 4'd1, 1, "b2b");
    step(0, 0, 0, 4'b0000, 4'd0, 12, "b2b");
    step(1, 0, 0, 4'b1001, 4'd3, 1, "abort");
    step(0, 0, 0, 4'b1001, 4'd3, 1, "abort");
    step(1, 0, 0, 4'b1111, 4'd3, 1, "abort");
    step(0, 1, 0, 4'b1111, 4'd3, 1, "abort");
    step(0, 0, 0, 4'b1111, 4'd3, 20, "abort");
    step(1, 1, 0, 4'b1111, 4'd0, 1, "abort_idle");
    step(0, 0, 0, 4'b1111, 4'd0, 3, "abort_idle");
    step(1, 0, 0, 4'b1010, 4'd1, 1, "rst_gap");
    step(0, 0, 0, 4'b1010, 4'd1, 4, "rst_gap");
    step(0, 0, 1, 4'b1010, 4'd1, 1, "rst_gap");
    step(1, 0, 0, 4'b0101, 4'd0, 1, "after_rst");
    step(0, 0, 0, 4'b0101, 4'd0, 7, "after_rst");
    step(1, 0, 0, 4'b1000, 4'd15, 1, "maxreps");
    step(0, 0, 0, 4'b1000, 4'd15, 84, "maxreps");
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
           4'($urandom), ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)), 1, "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
